// File: rtl/demux3_stream_router.sv
// 1-to-3 valid/ready stream router: steers each upstream beat to the lane
// picked by SL1/SL0, buffering it in a 2-entry per-lane FIFO with a beat counter.
module demux3_stream_router #(
  parameter int W  = 8,
  parameter int CW = 8
) (
  input  logic          CK,
  input  logic          RST,
  input  logic [W-1:0]  DIN,
  input  logic          VALID_IN,
  output logic          READY_IN,
  input  logic          SL0,
  input  logic          SL1,
  output logic [W-1:0]  Z0,
  output logic [W-1:0]  Z1,
  output logic [W-1:0]  Z2,
  output logic          VALID0,
  output logic          VALID1,
  output logic          VALID2,
  input  logic          READY0,
  input  logic          READY1,
  input  logic          READY2,
  output logic [CW-1:0] CNT0,
  output logic [CW-1:0] CNT1,
  output logic [CW-1:0] CNT2
);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [1:0]    sel;
  logic [2:0]    lane_rdy;
  logic [2:0]    ready_dn;
  logic [2:0]    push;
  logic [2:0]    pop;
  logic [2:0]    vld_p1;
  logic [1:0]    occ_p1  [3];
  logic [W-1:0]  head_p1 [3];
  logic [W-1:0]  tail_p1 [3];
  logic [CW-1:0] cnt_p1  [3];

  assign ready_dn = {READY2, READY1, READY0};

  // Stage p0: select decode and accept/pop decisions from registered occupancy only
  always_comb begin
    sel      = SL1 ? 2'd2 : (SL0 ? 2'd1 : 2'd0);
    READY_IN = 1'b0;
    push     = '0;
    pop      = '0;
    for (int i = 0; i < 3; i++) begin
      lane_rdy[i] = (occ_p1[i] != 2'd2);
      vld_p1[i]   = (occ_p1[i] != 2'd0);
      pop[i]      = vld_p1[i] & ready_dn[i];
    end
    case (sel)
      2'd0:    READY_IN = lane_rdy[0];
      2'd1:    READY_IN = lane_rdy[1];
      default: READY_IN = lane_rdy[2];
    endcase
    for (int i = 0; i < 3; i++)
      push[i] = VALID_IN & READY_IN & (sel == 2'(i));
  end

  // Stage p1: per-lane FIFO storage; head register feeds the lane output directly
  for (genvar g = 0; g < 3; g++) begin : g_lane
    always_ff @(posedge CK) begin
      if (RST) begin
        occ_p1[g]  <= '0;
        head_p1[g] <= '0;
        tail_p1[g] <= '0;
        cnt_p1[g]  <= '0;
      end else begin
        if (push[g] && pop[g]) begin
          if (occ_p1[g] == 2'd1) begin
            head_p1[g] <= DIN;
          end else begin
            head_p1[g] <= tail_p1[g];
            tail_p1[g] <= DIN;
          end
        end else if (push[g]) begin
          if (occ_p1[g] == 2'd0) head_p1[g] <= DIN;
          else                   tail_p1[g] <= DIN;
          occ_p1[g] <= occ_p1[g] + 2'd1;
        end else if (pop[g]) begin
          // Draining the last entry leaves head untouched so Z holds its value.
          if (occ_p1[g] == 2'd2) head_p1[g] <= tail_p1[g];
          occ_p1[g] <= occ_p1[g] - 2'd1;
        end
        if (push[g]) cnt_p1[g] <= sat_inc(cnt_p1[g]);
      end
    end
  end

  assign Z0     = head_p1[0];
  assign Z1     = head_p1[1];
  assign Z2     = head_p1[2];
  assign VALID0 = vld_p1[0];
  assign VALID1 = vld_p1[1];
  assign VALID2 = vld_p1[2];
  assign CNT0   = cnt_p1[0];
  assign CNT1   = cnt_p1[1];
  assign CNT2   = cnt_p1[2];

endmodule
